// File: rtl/keypad_pkg.sv
// Shared types and key encoding for the 4x3 keypad scanner.
// Codes: 0-9 as binary, # = 1010, * = 1011.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESS    = 2'd2,
      HOLD     = 2'd3
   } state_t;

   localparam logic [3:0] KEY_HASH = 4'b1010;
   localparam logic [3:0] KEY_STAR = 4'b1011;

   // Rows 0-2 carry digits 1-9 in reading order; row 3 is "* 0 #".
   function automatic logic [3:0] key_code(
      input logic [1:0] row,
      input logic [1:0] col
   );
      logic [3:0] code;
      code = 4'd0;
      if (row == 2'd3) begin
         case (col)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'd0;
            default: code = KEY_HASH;
         endcase
      end else begin
         code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
      end
      return code;
   endfunction

   function automatic logic [1:0] col_index(
      input logic [2:0] low
   );
      logic [1:0] idx;
      case (low)
         3'b001:  idx = 2'd0;
         3'b010:  idx = 2'd1;
         default: idx = 2'd2;
      endcase
      return idx;
   endfunction

   function automatic logic single_low(
      input logic [2:0] low
   );
      return (low == 3'b001) || (low == 3'b010) || (low == 3'b100);
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider: one-clock tick on the terminal count
// of a 0..DIV-1 counter, setting the row dwell period.
module keypad_tick_gen #(
   parameter int unsigned DIV = 1000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scan, debounce and encode front end.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 1000,
   parameter int unsigned DEBOUNCE_TICKS = 20,
   parameter int unsigned REPEAT_TICKS   = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] Code_1,
   output logic       Valid_1,
   output logic       S_Row
);

   localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);

   // An illegal parameter set leaves the scanner parked in reset state.
   localparam bit CFG_OK = (SCAN_DIV >= 4) &&
                           (DEBOUNCE_TICKS >= 1) &&
                           (REPEAT_TICKS >= 1);

   logic          tick;
   logic          scan_tick;
   logic [2:0]    col_s1;
   logic [2:0]    col_s2;
   logic [2:0]    col_low;
   logic          one_low;

   state_t        state;
   state_t        state_n;
   logic [1:0]    row_idx;
   logic [1:0]    row_n;
   logic [1:0]    cand_col;
   logic [1:0]    cand_col_n;
   logic [2:0]    cand_mask;
   logic          held_low;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [CW-1:0] cnt_inc;
   logic          cnt_done;
   logic [3:0]    code;
   logic [3:0]    code_n;
   logic          valid;
   logic          valid_n;
   logic          s_row;
   logic          s_row_n;

   keypad_tick_gen #(
      .DIV (SCAN_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign scan_tick = tick & CFG_OK;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_s1 <= 3'b111;
         col_s2 <= 3'b111;
      end else begin
         col_s1 <= col_in;
         col_s2 <= col_s1;
      end
   end

   assign col_low   = ~col_s2;
   assign one_low   = single_low(col_low);
   assign cand_mask = 3'b001 << cand_col;
   assign held_low  = |(col_low & cand_mask);
   assign cnt_inc   = cnt + 1'b1;
   assign cnt_done  = (cnt_inc == CW'(DEBOUNCE_TICKS));

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);

   logic [RW-1:0] rep;
   logic [RW-1:0] rep_n;
   logic [RW-1:0] rep_inc;
   logic          rep_fire;

   assign rep_inc = rep + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rep <= '0;
      end else begin
         rep <= rep_n;
      end
   end

   // Held ticks count only in HOLD; a release tick restarts the count.
   always_comb begin
      rep_n    = rep;
      rep_fire = 1'b0;
      if (state != HOLD) begin
         rep_n = '0;
      end else if (scan_tick) begin
         if (!held_low) begin
            rep_n = '0;
         end else if (rep_inc == RW'(REPEAT_TICKS)) begin
            rep_n    = '0;
            rep_fire = 1'b1;
         end else begin
            rep_n = rep_inc;
         end
      end
   end
`else
   logic rep_fire;

   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= SCAN;
         row_idx  <= 2'd0;
         cand_col <= 2'd0;
         cnt      <= '0;
         code     <= 4'd0;
         valid    <= 1'b0;
         s_row    <= 1'b0;
      end else begin
         state    <= state_n;
         row_idx  <= row_n;
         cand_col <= cand_col_n;
         cnt      <= cnt_n;
         code     <= code_n;
         valid    <= valid_n;
         s_row    <= s_row_n;
      end
   end

   always_comb begin
      state_n    = state;
      row_n      = row_idx;
      cand_col_n = cand_col;
      cnt_n      = cnt;
      code_n     = code;
      valid_n    = 1'b0;
      s_row_n    = s_row;
      unique case (state)
         SCAN: begin
            if (scan_tick) begin
               if (one_low) begin
                  cand_col_n = col_index(col_low);
                  cnt_n      = '0;
                  state_n    = DEBOUNCE;
               end else begin
                  row_n = row_idx + 2'd1;
               end
            end
         end
         DEBOUNCE: begin
            if (scan_tick) begin
               if (col_low == cand_mask) begin
                  if (cnt_done) begin
                     cnt_n   = '0;
                     code_n  = key_code(row_idx, cand_col);
                     s_row_n = 1'b1;
                     state_n = PRESS;
                  end else begin
                     cnt_n = cnt_inc;
                  end
               end else begin
                  cnt_n   = '0;
                  row_n   = row_idx + 2'd1;
                  state_n = SCAN;
               end
            end
         end
         PRESS: begin
            valid_n = 1'b1;
            cnt_n   = '0;
            state_n = HOLD;
         end
         HOLD: begin
            // Only the accepted column is watched, so extra keys are ignored.
            valid_n = rep_fire;
            if (scan_tick) begin
               if (held_low) begin
                  cnt_n = '0;
               end else if (cnt_done) begin
                  cnt_n   = '0;
                  s_row_n = 1'b0;
                  row_n   = row_idx + 2'd1;
                  state_n = SCAN;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
         end
      endcase
   end

   assign row_out = ~(4'b0001 << row_idx);
   assign Code_1  = code;
   assign Valid_1 = valid;
   assign S_Row   = s_row;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized bench for keypad_scanner with
// a behavioural keypad and key-map model.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DT = 3;
   localparam int RT = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] col_in;
   logic [3:0] row_out;
   logic [3:0] code;
   logic       valid;
   logic       s_row;

   logic [11:0] keys;

   int checks = 0;
   int errors = 0;

   int pulses = 0;
   int wide = 0;
   int pre_bad = 0;
   int srow_seen = 0;
   logic [3:0] last_code = 4'd0;
   logic [3:0] prev_code = 4'd0;
   logic       prev_valid = 1'b0;

   // Keypad layout as printed on the pad: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #.
   int key_code [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 0, 10};

   keypad_scanner #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_TICKS (DT),
      .REPEAT_TICKS   (RT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .col_in  (col_in),
      .row_out (row_out),
      .Code_1  (code),
      .Valid_1 (valid),
      .S_Row   (s_row)
   );

   always #5 clk = ~clk;

   always_comb begin
      col_in = 3'b111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (!row_out[r] && keys[r*3+c]) col_in[c] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (valid) begin
         if (!prev_valid) begin
            pulses++;
            last_code = code;
            if (code !== prev_code) pre_bad++;
         end else begin
            wide++;
         end
      end
      if (s_row) srow_seen++;
      prev_valid = valid;
      prev_code  = code;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_srow_low(input int limit, output int n);
      n = 0;
      while (s_row && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic press_key(input int idx, input int hold, input string tag);
      int p0;
      int n;
      p0 = pulses;
      keys[idx] = 1'b1;
      repeat (hold) @(negedge clk);
      keys = '0;
      wait_srow_low(40, n);
      chk({tag, "_srow_fall"}, int'(s_row), 0);
      repeat (8) @(negedge clk);
      chk({tag, "_pulses"}, pulses - p0, 1);
      chk({tag, "_code"}, int'(last_code), key_code[idx]);
   endtask

   initial begin
      int n;
      int m;
      int p0;
      int s0;
      int idx;
      int hold;
      logic [3:0] prev;
      logic [3:0] prev_row;

      keys  = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_row", int'(row_out), 4'b1110);
      chk("rst_code", int'(code), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_srow", int'(s_row), 0);
      reset = 1'b0;

      prev = row_out;
      for (int i = 0; i < 5; i++) begin
         n = 0;
         while (row_out === prev && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("rot_row", int'(row_out), int'({prev[2:0], prev[3]}));
         if (i > 0) chk("rot_gap", n, SD);
         prev = row_out;
      end

      p0 = pulses;
      keys[4] = 1'b1;
      n = 0;
      while (pulses == p0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("k5_latency_ok", int'(n <= (4 + DT) * SD + 4), 1);
      if (n < 40) repeat (40 - n) @(negedge clk);
      chk("k5_srow_held", int'(s_row), 1);
      keys = '0;
      wait_srow_low(40, m);
      chk("k5_release_ok", int'(m >= DT*SD - SD + 2 && m <= DT*SD + SD + 2), 1);
      repeat (8) @(negedge clk);
      chk("k5_pulses", pulses - p0, 1);
      chk("k5_code", int'(last_code), 5);

      press_key(11, 40, "hash");
      press_key(9, 40, "star");
      press_key(10, 40, "zero");

      p0 = pulses;
      s0 = srow_seen;
      prev_row = row_out;
      n = 0;
      while (!(row_out === 4'b1110 && prev_row === 4'b0111) && n < 40) begin
         prev_row = row_out;
         @(negedge clk);
         n++;
      end
      keys[0] = 1'b1;
      repeat (SD) @(negedge clk);
      keys = '0;
      repeat (6 * SD) @(negedge clk);
      chk("bounce_pulses", pulses - p0, 0);
      chk("bounce_srow", srow_seen - s0, 0);
      prev = row_out;
      n = 0;
      while (row_out === prev && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bounce_rescan", int'(row_out !== prev), 1);

      p0 = pulses;
      s0 = srow_seen;
      keys[0] = 1'b1;
      keys[1] = 1'b1;
      repeat (40) @(negedge clk);
      keys = '0;
      repeat (16) @(negedge clk);
      chk("dual_pulses", pulses - p0, 0);
      chk("dual_srow", srow_seen - s0, 0);

      p0 = pulses;
      keys[7] = 1'b1;
      n = 0;
      while (!s_row && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("hold_reached", int'(s_row), 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_row", int'(row_out), 4'b1110);
      chk("mid_rst_code", int'(code), 0);
      chk("mid_rst_valid", int'(valid), 0);
      chk("mid_rst_srow", int'(s_row), 0);
      keys = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_rst_pulses", pulses - p0, 1);

      p0 = pulses;
      keys[1] = 1'b1;
      repeat (30 * SD) @(negedge clk);
      keys = '0;
      wait_srow_low(40, n);
      repeat (8) @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
      chk("rep_pulses", int'(pulses - p0 >= 3), 1);
`else
      chk("rep_pulses", pulses - p0, 1);
`endif
      chk("rep_code", int'(last_code), 2);

      for (int i = 0; i < 6; i++) begin
         idx  = int'($urandom_range(0, 11));
         hold = int'($urandom_range(40, 64));
         press_key(idx, hold, "rand");
      end

      chk("valid_width", wide, 0);
      chk("code_before_valid", pre_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
